mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
//   NUM_REQ    : number of requesters sharing the memory
//   ID_W       : width of a requester id
//   req_id_t   : requester id type
//   rsp_tag_t  : per-port response tag {valid, id}, captured on a grant
//   make_tag   : builds the response tag from a one-hot grant vector
package mem_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

  localparam rsp_tag_t TAG_IDLE = '{valid: 1'b0, id: 1'b0};

  // The grant vector is one-hot or zero, so bit 1 alone identifies the winner.
  function automatic rsp_tag_t make_tag(input logic [NUM_REQ-1:0] grant);
    rsp_tag_t tag;
    tag.valid = |grant;
    tag.id    = req_id_t'(grant[1]);
    return tag;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req_i   : request vector, bit N = requester N contends
//   last_i  : id of the previous winner on this port
//   grant_o : one-hot grant (all zero when nobody requests)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  req_id_t            last_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // Lone contender always wins; on contention the requester that did not win last time wins.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: begin
        if (last_i == 1'b1) begin
          grant_o = 2'b01;
        end else begin
          grant_o = 2'b10;
        end
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto a memory with one read and one write port.
// Read and write ports are arbitrated independently (round-robin each), so a
// read and a write may issue in the same cycle. Every accepted request gets a
// response exactly one cycle later: read data from mem_rdata, or a write ack
// with zero data.
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid/we/addr/wdata : request from requester N (N = 0, 1)
//   reqN_ready               : requester N won its port this cycle
//   rspN_valid/rdata         : one-cycle response to requester N
//   mem_wen/waddr/wdata      : memory write port (driven from the write winner)
//   mem_ren/raddr            : memory read port (driven from the read winner)
//   mem_rdata                : registered memory read data, one cycle after mem_ren
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic [NUM_REQ-1:0] rd_req_s, wr_req_s;
  logic [NUM_REQ-1:0] rd_gnt_s, wr_gnt_s;
  req_id_t            rd_last_q, rd_last_d;
  req_id_t            wr_last_q, wr_last_d;
  rsp_tag_t           rd_tag_q, rd_tag_d;
  rsp_tag_t           wr_tag_q, wr_tag_d;

  // Requests are masked while in reset so nothing is granted or issued.
  assign rd_req_s = {req1_valid & ~req1_we, req0_valid & ~req0_we} & {NUM_REQ{~rst}};
  assign wr_req_s = {req1_valid &  req1_we, req0_valid &  req0_we} & {NUM_REQ{~rst}};

  rr_arb2 u_rd_arb (
    .req_i   (rd_req_s),
    .last_i  (rd_last_q),
    .grant_o (rd_gnt_s)
  );

  rr_arb2 u_wr_arb (
    .req_i   (wr_req_s),
    .last_i  (wr_last_q),
    .grant_o (wr_gnt_s)
  );

  // Ready handshakes and memory port muxing from the two winners.
  always_comb begin
    req0_ready = rd_gnt_s[0] | wr_gnt_s[0];
    req1_ready = rd_gnt_s[1] | wr_gnt_s[1];
    mem_ren    = |rd_gnt_s;
    mem_wen    = |wr_gnt_s;
    if (rd_gnt_s[1]) begin
      mem_raddr = req1_addr;
    end else if (rd_gnt_s[0]) begin
      mem_raddr = req0_addr;
    end else begin
      mem_raddr = '0;
    end
    if (wr_gnt_s[1]) begin
      mem_waddr = req1_addr;
      mem_wdata = req1_wdata;
    end else if (wr_gnt_s[0]) begin
      mem_waddr = req0_addr;
      mem_wdata = req0_wdata;
    end else begin
      mem_waddr = '0;
      mem_wdata = '0;
    end
  end

  // Next-state: pointers move only on a grant; tags record this cycle's winners.
  always_comb begin
    if (rd_gnt_s[1]) begin
      rd_last_d = req_id_t'(1'b1);
    end else if (rd_gnt_s[0]) begin
      rd_last_d = req_id_t'(1'b0);
    end else begin
      rd_last_d = rd_last_q;
    end
    if (wr_gnt_s[1]) begin
      wr_last_d = req_id_t'(1'b1);
    end else if (wr_gnt_s[0]) begin
      wr_last_d = req_id_t'(1'b0);
    end else begin
      wr_last_d = wr_last_q;
    end
    rd_tag_d = make_tag(rd_gnt_s);
    wr_tag_d = make_tag(wr_gnt_s);
  end

  // State registers; pointers reset to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_last_q <= req_id_t'(1'b1);
      wr_last_q <= req_id_t'(1'b1);
      rd_tag_q  <= TAG_IDLE;
      wr_tag_q  <= TAG_IDLE;
    end else begin
      rd_last_q <= rd_last_d;
      wr_last_q <= wr_last_d;
      rd_tag_q  <= rd_tag_d;
      wr_tag_q  <= wr_tag_d;
    end
  end

  // Responses decode straight from the registered tags; read data is the
  // memory's registered output, which lines up with the read tag.
  always_comb begin
    rsp0_valid = (rd_tag_q.valid && (rd_tag_q.id == 1'b0)) ||
                 (wr_tag_q.valid && (wr_tag_q.id == 1'b0));
    rsp1_valid = (rd_tag_q.valid && (rd_tag_q.id == 1'b1)) ||
                 (wr_tag_q.valid && (wr_tag_q.id == 1'b1));
    if (rd_tag_q.valid && (rd_tag_q.id == 1'b0)) begin
      rsp0_rdata = mem_rdata;
    end else begin
      rsp0_rdata = '0;
    end
    if (rd_tag_q.valid && (rd_tag_q.id == 1'b1)) begin
      rsp1_rdata = mem_rdata;
    end else begin
      rsp1_rdata = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [31:0] req0_addr = 32'h0, req0_wdata = 32'h0, req1_addr = 32'h0, req1_wdata = 32'h0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  // Contents of a never-written memory word.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 32'h0000_00AA;
      8'h20:   return 32'h0000_00BB;
      default: return 32'hC0DE_0000 | {24'h0, a};
    endcase
  endfunction

  // Memory environment: registered read, write-through forwarding on same address.
  logic [31:0] mem_arr [256];
  bit          mem_wr  [256];
  always @(posedge clk) begin
    if (mem_ren) begin
      if (mem_wen && (mem_waddr == mem_raddr))
        mem_rdata <= mem_wdata;
      else
        mem_rdata <= mem_wr[mem_raddr[7:0]] ? mem_arr[mem_raddr[7:0]] : init_val(mem_raddr[7:0]);
    end
    if (mem_wen) begin
      mem_arr[mem_waddr[7:0]] <= mem_wdata;
      mem_wr[mem_waddr[7:0]]  <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] sh_arr [256];
  bit          sh_wr  [256];
  int          m_rd_last = 1, m_wr_last = 1;
  bit          exp_v [2];
  logic [31:0] exp_d [2];
  bit          last_rdy0, last_rdy1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin winner: -1 none, otherwise requester index.
  function automatic int pick(input bit c0, input bit c1, input int last);
    if (c0 && c1) return (last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] sh_read(input logic [31:0] a);
    return sh_wr[a[7:0]] ? sh_arr[a[7:0]] : init_val(a[7:0]);
  endfunction

  // One cycle: check due responses, drive request, check grants/ports, advance model.
  task automatic step(input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    int rw, ww;
    logic [31:0] ra, wa, wd;
    chk("rsp0_valid", rsp0_valid, exp_v[0]);
    chk("rsp0_rdata", rsp0_rdata, exp_v[0] ? exp_d[0] : 32'h0);
    chk("rsp1_valid", rsp1_valid, exp_v[1]);
    chk("rsp1_rdata", rsp1_rdata, exp_v[1] ? exp_d[1] : 32'h0);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    rw = pick(v0 && !w0, v1 && !w1, m_rd_last);
    ww = pick(v0 && w0, v1 && w1, m_wr_last);
    chk("req0_ready", req0_ready, (rw == 0) || (ww == 0));
    chk("req1_ready", req1_ready, (rw == 1) || (ww == 1));
    last_rdy0 = req0_ready;
    last_rdy1 = req1_ready;
    chk("mem_ren", mem_ren, rw >= 0);
    chk("mem_wen", mem_wen, ww >= 0);
    ra = (rw == 1) ? a1 : a0;
    wa = (ww == 1) ? a1 : a0;
    wd = (ww == 1) ? d1 : d0;
    if (rw >= 0) chk("mem_raddr", mem_raddr, ra);
    if (ww >= 0) begin
      chk("mem_waddr", mem_waddr, wa);
      chk("mem_wdata", mem_wdata, wd);
    end
    exp_v[0] = 1'b0; exp_v[1] = 1'b0;
    if (rw >= 0) begin
      exp_v[rw] = 1'b1;
      exp_d[rw] = (ww >= 0 && wa == ra) ? wd : sh_read(ra);
      m_rd_last = rw;
    end
    if (ww >= 0) begin
      exp_v[ww] = 1'b1;
      exp_d[ww] = 32'h0;
      sh_arr[wa[7:0]] = wd;
      sh_wr[wa[7:0]]  = 1'b1;
      m_wr_last = ww;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready0"}, req0_ready, 1'b0);
    chk({tag, "_ready1"}, req1_ready, 1'b0);
    chk({tag, "_rsp0v"}, rsp0_valid, 1'b0);
    chk({tag, "_rsp1v"}, rsp1_valid, 1'b0);
    chk({tag, "_rsp0d"}, rsp0_rdata, 32'h0);
    chk({tag, "_rsp1d"}, rsp1_rdata, 32'h0);
    chk({tag, "_ren"}, mem_ren, 1'b0);
    chk({tag, "_wen"}, mem_wen, 1'b0);
    chk({tag, "_raddr"}, mem_raddr, 32'h0);
    chk({tag, "_waddr"}, mem_waddr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  // Reset with requests still presented, to show they are ignored while rst is high.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h7;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h9; req1_wdata = 32'hDEAD;
    #1;
    check_quiet("rst");
    exp_v[0] = 1'b0; exp_v[1] = 1'b0;
    m_rd_last = 1; m_wr_last = 1;
    repeat (cycles) @(posedge clk);
    #1;
    check_quiet("rst_hold");
    req0_valid = 1'b0; req1_valid = 1'b0; req1_we = 1'b0;
    req0_addr = 32'h0; req1_addr = 32'h0; req1_wdata = 32'h0;
    rst = 1'b0;
  endtask

  initial begin
    exp_v[0] = 1'b0; exp_v[1] = 1'b0;
    exp_d[0] = 32'h0; exp_d[1] = 32'h0;
    do_reset(2);

    // Contested reads after reset: requester 0 first.
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("t033_rdy0", last_rdy0, 1'b1);
    chk("t033_rdy1", last_rdy1, 1'b0);
    chk("t033_model", exp_d[0], 32'hAA);
    chk("t033_rsp0", rsp0_rdata, 32'hAA);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("t033_rdy1b", last_rdy1, 1'b1);
    chk("t033_rsp1", rsp1_rdata, 32'hBB);
    chk("t033_rsp1v", rsp1_valid, 1'b1);
    idle();

    // Same-address write and read in one cycle.
    step(1'b1, 1'b1, 32'h5, 32'h1234, 1'b1, 1'b0, 32'h5, 32'h0);
    chk("t034_rdy0", last_rdy0, 1'b1);
    chk("t034_rdy1", last_rdy1, 1'b1);
    chk("t034_rsp0v", rsp0_valid, 1'b1);
    chk("t034_rsp0d", rsp0_rdata, 32'h0);
    chk("t034_rsp1d", rsp1_rdata, 32'h1234);
    idle();

    // Continuous contested writes alternate 0,1,0,1,...
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 32'h40 + i, 32'h100 + i, 1'b1, 1'b1, 32'h50 + i, 32'h200 + i);
      chk("t035_rdy0", last_rdy0, (i % 2) == 0);
      chk("t035_rdy1", last_rdy1, (i % 2) == 1);
    end
    idle();

    // Back-to-back reads from requester 1 alone.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, i, 32'h0);
      chk("t036_rdy1", last_rdy1, 1'b1);
      chk("t036_rsp1v", rsp1_valid, 1'b1);
      chk("t036_rsp1d", rsp1_rdata, 32'hC0DE_0000 + i);
    end
    idle();

    // Reset right after a read grant drops its response.
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t037_rdy0", last_rdy0, 1'b1);
    do_reset(2);
    chk("t037_rsp0v", rsp0_valid, 1'b0);
    idle();
    idle();
    step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("t037_first0", last_rdy0, 1'b1);
    chk("t037_first1", last_rdy1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
